// File: rtl/stream_q_pkg.sv
// Shared constants, pointer-width helper and token type for the page stream queues.
package stream_q_pkg;

  localparam int STREAM_Q_WIDTH = 16;
  localparam int STREAM_Q_DEPTH = 8;
  localparam int STREAM_Q_SLACK = 2;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Default-width token; queues built with another WIDTH declare the same layout locally.
  typedef struct packed {
    logic                      e;
    logic [STREAM_Q_WIDTH-1:0] d;
  } stream_tok_t;

endpackage

// File: rtl/stream_q_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module stream_q_regfile #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/page_stream_in_q.sv
// Receive-side stream input queue with registered early backpressure and fall-through output.
// Optional sticky overflow flag and overflow assertion: define STREAM_INQ_OVF_CHECK_EN.
module page_stream_in_q
  import stream_q_pkg::*;
#(
  parameter int WIDTH = STREAM_Q_WIDTH,
  parameter int DEPTH = STREAM_Q_DEPTH,
  parameter int SLACK = STREAM_Q_SLACK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_e,
  input  logic             in_v,
  output logic             in_b,
  output logic [WIDTH-1:0] out_d,
  output logic             out_e,
  output logic             out_v,
  input  logic             out_b
`ifdef STREAM_INQ_OVF_CHECK_EN
  ,
  output logic             ovf
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             e;
    logic [WIDTH-1:0] d;
  } tok_t;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_b_q, in_b_d;
  logic          full, pop, wr_en;
  tok_t          wr_tok, rd_tok;

  // Full is judged by count; a pop in the same cycle frees the slot being written.
  assign full  = (count_q == CW'(DEPTH));
  assign out_v = (count_q != '0);
  assign pop   = out_v & ~out_b;
  assign wr_en = in_v & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    in_b_d = (count_d >= CW'(DEPTH - SLACK));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_b_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      in_b_q   <= in_b_d;
    end
  end

  assign in_b   = in_b_q;
  assign wr_tok = '{e: in_e, d: in_d};

  stream_q_regfile #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clock   (clock),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_tok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_tok)
  );

  // Storage is not reset, so mask the head while empty to keep outputs at zero.
  assign out_d = out_v ? rd_tok.d : '0;
  assign out_e = out_v & rd_tok.e;

`ifdef STREAM_INQ_OVF_CHECK_EN
  logic overflow, ovf_q;
  assign overflow = in_v & full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        ovf_q <= 1'b0;
    else if (overflow) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset) assert (!overflow) else $error("page_stream_in_q: overflow, token dropped");
  end
`endif
`endif

endmodule

// File: tb/tb_page_stream_in_q.sv
// Directed bench for page_stream_in_q with a token scoreboard queue.
module tb_page_stream_in_q;

  localparam int W = 16;
  localparam int D = 8;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_d  = '0;
  logic         in_e  = 1'b0;
  logic         in_v  = 1'b0;
  logic         out_b = 1'b1;
  logic         in_b, out_e, out_v;
  logic [W-1:0] out_d;
`ifdef STREAM_INQ_OVF_CHECK_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic exp_inb = 1'b0;

  always #5 clock = ~clock;

  page_stream_in_q #(.WIDTH(W), .DEPTH(D), .SLACK(S)) dut (
    .clock (clock),
    .reset (reset),
    .in_d  (in_d),
    .in_e  (in_e),
    .in_v  (in_v),
    .in_b  (in_b),
    .out_d (out_d),
    .out_e (out_e),
    .out_v (out_v),
    .out_b (out_b)
`ifdef STREAM_INQ_OVF_CHECK_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s disagreed", tag);
    end
  endtask

  // One clock: drive inputs, check outputs at the negedge, update the model at the posedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic e, input logic b);
    bit do_pop, do_push;
    in_v = v; in_d = d; in_e = e; out_b = b;
    @(negedge clock);
    chk("out_v", 32'(out_v), 32'(exp_q.size() != 0));
    chk("in_b", 32'(in_b), 32'(exp_inb));
    if (exp_q.size() != 0) begin
      chk("out_d", 32'(out_d), 32'(exp_q[0][W-1:0]));
      chk("out_e", 32'(out_e), 32'(exp_q[0][W]));
    end else begin
      chk("out_d_idle", 32'(out_d), 32'd0);
    end
    do_pop  = (exp_q.size() != 0) && !b;
    do_push = v && ((exp_q.size() < D) || do_pop);
    @(posedge clock);
    if (do_pop) begin
      $display("pop  d=%h e=%0d", exp_q[0][W-1:0], exp_q[0][W]);
      void'(exp_q.pop_front());
    end
    if (do_push) begin
      exp_q.push_back({e, d});
      $display("push d=%h e=%0d", d, e);
    end else if (v) begin
      $display("drop d=%h", d);
    end
    exp_inb = (exp_q.size() >= D - S);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    // Reset held low for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_in_b", 32'(in_b), 32'd0);
      chk("rst_out_v", 32'(out_v), 32'd0);
      chk("rst_out_d", 32'(out_d), 32'd0);
      chk("rst_out_e", 32'(out_e), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("idle_out_v", 32'(out_v), 32'd0);

    // Single token held under consumer backpressure.
    cycle(1'b1, 16'h1234, 1'b0, 1'b1);
    chk("single_v", 32'(out_v), 32'd1);
    chk("single_d", 32'(out_d), 32'h1234);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("single_held", 32'(out_d), 32'h1234);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("single_empty", 32'(out_v), 32'd0);

    // Backpressure timing.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b1);
      if (i == 4) chk("inb_cnt5", 32'(in_b), 32'd0);
    end
    chk("inb_cnt6", 32'(in_b), 32'd1);
    cycle(1'b1, W'(6), 1'b0, 1'b1);
    cycle(1'b1, W'(7), 1'b0, 1'b1);
    chk("inb_cnt8", 32'(in_b), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      if (i == 1) chk("drain_cnt6", 32'(in_b), 32'd1);
      if (i == 2) chk("drain_cnt5", 32'(in_b), 32'd0);
    end
    chk("drain_empty", 32'(out_v), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(16'h0180 + i), 1'b0, 1'b0);
    chk("full_pp_inb", 32'(in_b), 32'd1);
    chk("full_pp_cnt", 32'(exp_q.size()), 32'd8);
`ifdef STREAM_INQ_OVF_CHECK_EN
    chk("full_pp_ovf", 32'(ovf), 32'd0);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("full_pp_empty", 32'(out_v), 32'd0);

    // End-of-stream and pointer wrap with random consumer backpressure.
    idx = 0;
    for (int c = 0; c < 300 && idx < 20; c++) begin
      if (!in_b) begin
        cycle(1'b1, W'(16'hA000 + idx), (idx == 19), 1'($urandom_range(0, 1)));
        idx++;
      end else begin
        cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    chk("wrap_sent", 32'(idx), 32'd20);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    chk("wrap_out_v", 32'(out_v), 32'd0);

    // Overflow: ninth token into a full queue is dropped.
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(16'h0200 + i), 1'b0, 1'b1);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("ovf_head", 32'(out_d), 32'h0200);
`ifdef STREAM_INQ_OVF_CHECK_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`endif
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_drained", 32'(out_v), 32'd0);
`ifdef STREAM_INQ_OVF_CHECK_EN
    chk("ovf_sticky", 32'(ovf), 32'd1);
`endif

    // Reset mid-stream drops in_b asynchronously and discards tokens.
    for (int i = 0; i < 7; i++) cycle(1'b1, W'(16'h0300 + i), 1'b0, 1'b1);
    chk("mid_inb_hi", 32'(in_b), 32'd1);
    in_v = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_inb", 32'(in_b), 32'd0);
    chk("mid_rst_out_v", 32'(out_v), 32'd0);
    chk("mid_rst_out_d", 32'(out_d), 32'd0);
`ifdef STREAM_INQ_OVF_CHECK_EN
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    exp_q.delete();
    exp_inb = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'h4321, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_stream_in_q.md
Name: page_stream_in_q

Overview:
- Receive-side input queue for a page's inbound stream ports, the consumer end of the (d, e, v, b) stream protocol driven by page output queues.
- Accepts tokens unconditionally whenever valid is high, buffers them, and issues registered backpressure early enough to absorb in-flight tokens.
- Presents a fall-through (d, e, v) interface to the page FSM/datapath, which pops with its own b.

Parameters:
WIDTH, 16, data bits per token (excludes the e flag)
DEPTH, 8, token slots; power of two, >= 4
SLACK, 2, slots reserved for tokens in flight after in_b asserts; 1 <= SLACK < DEPTH

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset; named reset as elsewhere in the codebase
in_d  in  WIDTH  upstream token data
in_e  in  1  upstream end-of-stream flag, travels with the token
in_v  in  1  upstream token valid; a token is pushed every cycle in_v=1
in_b  out  1  registered backpressure to upstream
out_d  out  WIDTH  head token data
out_e  out  1  head token end-of-stream flag
out_v  out  1  queue non-empty
out_b  in  1  consumer backpressure; pop occurs when out_v=1 and out_b=0
`ifdef: ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): count=0, rd/wr pointers=0, in_b=0, out_v=0, out_d=0, out_e=0; storage contents don't-care.
- Push = in_v. Pop = out_v & ~out_b.
- Storage holds WIDTH+1 bits per slot {e, d}; e is carried unchanged, no special treatment.
- Write: on a push with room, {in_e, in_d} is written at wr_ptr, wr_ptr increments mod DEPTH, count increments.
- Latency: a token pushed in cycle N appears at out_v/out_d in cycle N+1. There is no combinational in->out path.
- Read: out_d/out_e = storage[rd_ptr], combinational from the register array; out_v = (count != 0).
- On pop: rd_ptr increments mod DEPTH, count decrements.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal even when count=DEPTH, because the pop frees the slot the push fills.
- Push with count=DEPTH and no pop is an overflow. The token is dropped; pointers and count are unchanged.
- in_b is registered: in_b <= (count_next >= DEPTH-SLACK), where count_next is the post-update count. in_b deasserts on the first cycle count_next < DEPTH-SLACK.
- Upstream contract: at most SLACK tokens arrive after the cycle in_b is first seen high. Under that contract overflow is impossible.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are determined by count, not by pointer comparison.
- out_b while out_v=0 has no effect.
- Reset mid-stream discards all buffered tokens. in_b drops low asynchronously with reset assertion.

Optional Feature:
- Macro STREAM_INQ_OVF_CHECK_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - ovf sets on the cycle after any overflow and holds until reset.
  - Simulation-only assertion: error message when an overflow occurs.
- Undefined:
  - No ovf port, no assertion.
  - Overflowing tokens are silently dropped; all other behaviour is identical.

Decomposition:
- Package stream_q_pkg holds:
  - a clog2-based pointer-width constant function
  - the token struct typedef {e, d} parameterised via WIDTH at use site
  - the default constants WIDTH=16, DEPTH=8, SLACK=2, shared with the output-side queue
- One sub-module: stream_q_regfile, a DEPTH x (WIDTH+1) register array with one synchronous write port and one combinational read port, no reset on data.

Test Plan:
- Reset then idle, reset=0 for 3 cycles -> in_b=0, out_v=0, out_d=0, out_e=0; after release the outputs stay there with in_v=0.
- Single token: push in_d=16'h1234, in_e=0 at cycle N with out_b=1 -> out_v=1, out_d=16'h1234 at N+1, held until out_b=0, then out_v=0 the next cycle.
- Backpressure timing (DEPTH=8, SLACK=2):
  - stimulus: stream 0..5 back-to-back with out_b=1
  - in_b rises the cycle after the 6th push (count=6)
  - then push 2 more -> count=8, no overflow
  - then drain with out_b=0 -> outputs in order 0..7, in_b falls the cycle after count drops to 5.
- Full with simultaneous push/pop: count=8, in_v=1, out_b=0 for 4 cycles -> count stays 8, order preserved, no overflow (ovf=0 when STREAM_INQ_OVF_CHECK_EN is defined).
- EOS and wrap: push 20 tokens, the 20th with in_e=1, with random out_b -> out_e=1 only on the 20th token, data order is exact across pointer wrap.
- Overflow (STREAM_INQ_OVF_CHECK_EN defined): fill to 8, push 16'hDEAD with out_b=1 -> DEAD never appears at out_d, ovf=1 next cycle and stays 1 until reset.
